// File: rtl/audio_gain_stage.sv
// N-channel audio gain stage: bypass / gain / mute with a de-zipper gain ramp and saturation.
// One registered multiplier is shared across channels and sequenced by a small FSM.
module audio_gain_stage #(
    parameter int DATA_W    = 24,
    parameter int NUM_CH    = 2,
    parameter int GAIN_W    = 16,
    parameter int RAMP_STEP = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_data_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [1:0]               i_mode,
    input  logic [GAIN_W-1:0]        i_gain_target,
    output logic                     o_data_valid,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    output logic [NUM_CH-1:0]        o_clip,
    output logic                     o_busy,
    output logic                     o_overrun
);

    // state | meaning
    // IDLE  | waiting for a frame; latch frame, mode and ramped gain on i_data_valid
    // CALC  | one channel per cycle through the multiplier, plus one drain cycle
    // DONE  | publish o_data / o_clip and pulse o_data_valid
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int IDX_W  = $clog2(NUM_CH + 1);

    localparam logic [GAIN_W-1:0]        UNITY    = GAIN_W'(1) << (GAIN_W - 2);
    localparam logic [GAIN_W-1:0]        STEP     = GAIN_W'(RAMP_STEP);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CH);
    localparam logic signed [PROD_W-1:0] SAT_MAX  = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN  = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t state, state_nxt;

    logic [NUM_CH*DATA_W-1:0] frame_r;
    logic [NUM_CH*DATA_W-1:0] res_r;
    logic [NUM_CH-1:0]        clip_r;
    logic                     bypass_r;
    logic [GAIN_W-1:0]        g_cur;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         wr_idx;
    logic signed [PROD_W-1:0] prod_r;
    logic [DATA_W-1:0]        samp_r;

    logic [GAIN_W-1:0]        g_tgt;
    logic [GAIN_W-1:0]        g_diff;
    logic [GAIN_W-1:0]        g_next;
    logic [DATA_W-1:0]        sample_sel;
    logic signed [PROD_W-1:0] mul_a;
    logic signed [PROD_W-1:0] mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic [DATA_W-1:0]        res_val;
    logic                     clip_val;

    always_comb begin
        g_tgt  = UNITY;
        g_diff = '0;
        g_next = g_cur;
        case (i_mode)
            2'b01:   g_tgt = i_gain_target;
            2'b10:   g_tgt = '0;
            default: g_tgt = UNITY;
        endcase
        if (RAMP_STEP == 0) begin
            g_next = g_tgt;
        end else if (g_tgt >= g_cur) begin
            g_diff = g_tgt - g_cur;
            g_next = g_cur + ((g_diff > STEP) ? STEP : g_diff);
        end else begin
            g_diff = g_cur - g_tgt;
            g_next = g_cur - ((g_diff > STEP) ? STEP : g_diff);
        end
    end

    always_comb begin
        sample_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) sample_sel = frame_r[k*DATA_W +: DATA_W];
        end
    end

    // Both operands are sign-extended to the full product width so the product is exact.
    assign mul_a = PROD_W'($signed(sample_sel));
    assign mul_b = PROD_W'($signed({1'b0, g_cur}));
    assign prod  = mul_a * mul_b;

    assign shifted = prod_r >>> (GAIN_W - 2);
    assign wr_idx  = idx - IDX_W'(1);

    always_comb begin
        res_val  = shifted[DATA_W-1:0];
        clip_val = 1'b0;
        if (bypass_r) begin
            res_val = samp_r;
        end else if (shifted > SAT_MAX) begin
            res_val  = {1'b0, {(DATA_W-1){1'b1}}};
            clip_val = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res_val  = {1'b1, {(DATA_W-1){1'b0}}};
            clip_val = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_data_valid) state_nxt = CALC;
            CALC:    if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_r      <= '0;
            res_r        <= '0;
            clip_r       <= '0;
            bypass_r     <= 1'b0;
            g_cur        <= UNITY;
            idx          <= '0;
            prod_r       <= '0;
            samp_r       <= '0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_clip       <= '0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_overrun    <= i_data_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (i_data_valid) begin
                        frame_r  <= i_data;
                        bypass_r <= (i_mode == 2'b00) || (i_mode == 2'b11);
                        g_cur    <= g_next;
                        idx      <= '0;
                        o_busy   <= 1'b1;
                    end
                end
                CALC: begin
                    // Product for channel idx is registered; channel idx-1 is saturated and stored.
                    prod_r <= prod;
                    samp_r <= sample_sel;
                    if (idx != '0) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (wr_idx == IDX_W'(k)) begin
                                res_r[k*DATA_W +: DATA_W] <= res_val;
                                clip_r[k]                 <= clip_val;
                            end
                        end
                    end
                    idx <= idx + IDX_W'(1);
                end
                DONE: begin
                    o_data       <= res_r;
                    o_clip       <= clip_r;
                    o_data_valid <= 1'b1;
                    o_busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
